// File: rtl/trgg_pkg.sv
// ============================================================================
// Module      : trgg_pkg
// Description : Shared mode codes, INV bit index and channel state encoding
//               for the multi-channel trigger-output generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trgg_pkg;

    // Mode field, bits [2:0]; codes 3..7 are reserved and behave as OFF
    localparam logic [2:0] TRGG_OFF   = 3'd0;
    localparam logic [2:0] TRGG_PULSE = 3'd1;
    localparam logic [2:0] TRGG_GATE  = 3'd2;

    // Mode field bit that inverts the pin polarity
    localparam int TRGG_INV_BIT = 3;

    // Per-channel state encoding
    localparam logic [1:0] TRGG_IDLE   = 2'd0;
    localparam logic [1:0] TRGG_WAIT   = 2'd1;
    localparam logic [1:0] TRGG_ACTIVE = 2'd2;
    localparam logic [1:0] TRGG_DONE   = 2'd3;

    typedef logic [1:0] trgg_state_t;

    function automatic logic trgg_is_running(input trgg_state_t st);
        return (st == TRGG_WAIT) || (st == TRGG_ACTIVE);
    endfunction

endpackage : trgg_pkg

`default_nettype wire

// File: rtl/trgg_gen_ch.sv
// ============================================================================
// Module      : trgg_gen_ch
// Description : One trigger channel: latches mode/delay on start, then runs a
//               delayed PULSE or a GATE and parks in DONE until released.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trgg_gen_ch
    import trgg_pkg::*;
#(
    parameter int MW      = 4,
    parameter int DW      = 16,
    parameter int PULSE_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_release,
    input  logic          i_abort,
    input  logic [MW-1:0] i_mode,
    input  logic [DW-1:0] i_delay,
    output logic          o_pin,
    output logic          o_done,
    output logic          o_idle
);

    localparam logic [DW-1:0] c_PULSE_W = DW'(PULSE_W);
    localparam logic [DW-1:0] c_ONE     = DW'(1);

    trgg_state_t   r_state;
    logic [DW-1:0] r_cnt;
    logic          r_inv;
    logic [2:0]    w_kind;

    assign w_kind = i_mode[2:0];

    generate
        if (MW > 4) begin : g_upper_mode
            logic w_unused_mode;
            assign w_unused_mode = ^i_mode[MW-1:4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TRGG_IDLE;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
        end else if (i_abort && trgg_is_running(r_state)) begin
            // A channel already in DONE stays put, so a release is never masked
            r_state <= TRGG_DONE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                TRGG_IDLE: begin
                    if (i_start) begin
                        r_inv <= i_mode[TRGG_INV_BIT];
                        r_cnt <= i_delay;
                        case (w_kind)
                            TRGG_PULSE: r_state <= TRGG_WAIT;
                            TRGG_GATE:  r_state <= (i_delay != '0) ? TRGG_ACTIVE : TRGG_DONE;
                            default:    r_state <= TRGG_DONE;
                        endcase
                    end
                end
                TRGG_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= TRGG_ACTIVE;
                        r_cnt   <= c_PULSE_W;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                TRGG_ACTIVE: begin
                    if (r_cnt == c_ONE) begin
                        r_state <= TRGG_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                TRGG_DONE: begin
                    if (i_release) begin
                        r_state <= TRGG_IDLE;
                    end
                end
                default: r_state <= TRGG_IDLE;
            endcase
        end
    end

    // Pin depends only on registered state, never on the command inputs
    assign o_pin  = (r_state == TRGG_ACTIVE) ^ r_inv;
    assign o_done = (r_state == TRGG_DONE);
    assign o_idle = (r_state == TRGG_IDLE);

endmodule : trgg_gen_ch

`default_nettype wire

// File: rtl/trgg_gen.sv
// ============================================================================
// Module      : trgg_gen
// Description : NCH-channel trigger-output generator with fs/fd handshake.
//               Optional macro TRGG_ABORT_EN adds an abort input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trgg_gen
    import trgg_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MW      = 4,
    parameter int DW      = 16,
    parameter int PULSE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fs,
`ifdef TRGG_ABORT_EN
    input  logic                    abort,
`endif
    input  logic [0:NCH*(MW+DW)-1]  trgg_cmd,
    output logic                    fd,
    output logic [0:NCH-1]          pin_out,
    output logic [0:NCH-1]          ch_done
);

    logic [NCH-1:0] w_idle;
    logic [NCH-1:0] w_done;
    logic           w_start;
    logic           w_release;
    logic           w_abort;
    logic           r_fd;

`ifdef TRGG_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // A start is only accepted once every channel is back in IDLE
    assign w_start   = fs & (&w_idle);
    assign w_release = r_fd & ~fs;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            trgg_gen_ch #(
                .MW      (MW),
                .DW      (DW),
                .PULSE_W (PULSE_W)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .i_start   (w_start),
                .i_release (w_release),
                .i_abort   (w_abort),
                .i_mode    (trgg_cmd[MW*gi +: MW]),
                .i_delay   (trgg_cmd[NCH*MW + DW*gi +: DW]),
                .o_pin     (pin_out[gi]),
                .o_done    (w_done[gi]),
                .o_idle    (w_idle[gi])
            );
            assign ch_done[gi] = w_done[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fd <= 1'b0;
        end else if (w_release) begin
            r_fd <= 1'b0;
        end else begin
            r_fd <= &w_done;
        end
    end

    assign fd = r_fd;

endmodule : trgg_gen

`default_nettype wire

// File: tb/tb_trgg_gen.sv
// ============================================================================
// Module      : tb_trgg_gen
// Description : Randomized self-checking bench for trgg_gen against a
//               window-based timing model of each channel.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_trgg_gen;

    localparam int NCH     = 4;
    localparam int MW      = 4;
    localparam int DW      = 12;
    localparam int PULSE_W = 8;
    localparam int CW      = NCH*(MW+DW);
    localparam int MAX_D   = (1 << DW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            fs;
    logic [0:CW-1]   trgg_cmd;
    logic            fd;
    logic [0:NCH-1]  pin_out;
    logic [0:NCH-1]  ch_done;
`ifdef TRGG_ABORT_EN
    logic            abort;
`endif

    trgg_gen #(
        .NCH     (NCH),
        .MW      (MW),
        .DW      (DW),
        .PULSE_W (PULSE_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fs       (fs),
`ifdef TRGG_ABORT_EN
        .abort    (abort),
`endif
        .trgg_cmd (trgg_cmd),
        .fd       (fd),
        .pin_out  (pin_out),
        .ch_done  (ch_done)
    );

    always #5 clk = ~clk;

    int             n_vec = 0;
    int             n_err = 0;
    logic [0:NCH-1] idle_lvl = '0;
    logic [3:0]     t_mode [NCH];
    int             t_dly  [NCH];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abort(input logic v);
`ifdef TRGG_ABORT_EN
        abort = v;
`else
        if (v) $display("note: abort requested without TRGG_ABORT_EN");
`endif
    endtask

    task automatic check_idle(input string name);
        check_val({name, ".idle_pin"},  32'(pin_out), 32'(idle_lvl));
        check_val({name, ".idle_done"}, 32'(ch_done), 32'd0);
        check_val({name, ".idle_fd"},   32'(fd),      32'd0);
    endtask

    // One full command: latch, run, optional hold of fs, release, one idle edge
    task automatic run_cmd(input string name, input int fs_drop, input int hold,
                           input int rst_at, input int abort_in);
        int             a_lo [NCH];
        int             a_hi [NCH];
        int             d_edge [NCH];
        int             fd_edge;
        int             raw_max;
        int             abort_at;
        int             k;
        logic           fs_at_edge;
        logic           released;
        logic [0:NCH-1] inv;
        logic [0:NCH-1] exp_pin;
        logic [0:NCH-1] exp_done;

        raw_max = 0;
        for (int i = 0; i < NCH; i++) begin
            inv[i]    = t_mode[i][3];
            a_lo[i]   = 1;
            a_hi[i]   = 0;
            d_edge[i] = 0;
            if (t_mode[i][2:0] == 3'd1) begin
                a_lo[i]   = t_dly[i] + 1;
                a_hi[i]   = t_dly[i] + PULSE_W;
                d_edge[i] = t_dly[i] + 1 + PULSE_W;
            end else if (t_mode[i][2:0] == 3'd2 && t_dly[i] > 0) begin
                a_lo[i]   = 0;
                a_hi[i]   = t_dly[i] - 1;
                d_edge[i] = t_dly[i];
            end
            if (d_edge[i] > raw_max) raw_max = d_edge[i];
        end
        abort_at = (abort_in >= 1 && abort_in < raw_max) ? abort_in : -1;
        fd_edge = 0;
        for (int i = 0; i < NCH; i++) begin
            if (abort_at >= 0 && abort_at < d_edge[i]) begin
                d_edge[i] = abort_at;
                if (a_hi[i] >= abort_at) a_hi[i] = abort_at - 1;
            end
            if (d_edge[i] + 1 > fd_edge) fd_edge = d_edge[i] + 1;
        end

        check_idle({name, ".pre"});
        for (int i = 0; i < NCH; i++) begin
            trgg_cmd[MW*i +: MW]          = MW'(t_mode[i]);
            trgg_cmd[NCH*MW + DW*i +: DW] = DW'(t_dly[i]);
        end
        fs = 1'b1;
        k = 0;
        released = 1'b0;
        while (!released) begin
            fs_at_edge = fs;
            tick();
            if (k == rst_at) begin
                check_val({name, ".rst_pin"},  32'(pin_out), 32'd0);
                check_val({name, ".rst_done"}, 32'(ch_done), 32'd0);
                check_val({name, ".rst_fd"},   32'(fd),      32'd0);
                rst = 1'b0;
                fs = 1'b0;
                idle_lvl = '0;
                tick();
                check_idle({name, ".post_rst"});
                return;
            end
            if (k > fd_edge && !fs_at_edge) begin
                exp_pin  = inv;
                exp_done = '0;
                released = 1'b1;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    exp_pin[i]  = inv[i] ^ (k >= a_lo[i] && k <= a_hi[i]);
                    exp_done[i] = (k >= d_edge[i]);
                end
            end
            check_val($sformatf("%s.pin k=%0d", name, k),  32'(pin_out), 32'(exp_pin));
            check_val($sformatf("%s.done k=%0d", name, k), 32'(ch_done), 32'(exp_done));
            check_val($sformatf("%s.fd k=%0d", name, k),   32'(fd),
                      32'(!released && k >= fd_edge));
            if (k == 0) trgg_cmd = {$urandom, $urandom};
            if (fs_drop >= 0 && k >= fs_drop) fs = 1'b0;
            if (k >= fd_edge + hold) fs = 1'b0;
            set_abort(abort_at >= 0 && k + 1 == abort_at);
            if (k + 1 == rst_at) rst = 1'b1;
            k++;
            if (!released && k > fd_edge + hold + 4) begin
                check_val({name, ".release_timeout"}, 32'(k), 32'(fd_edge + hold + 2));
                released = 1'b1;
            end
        end
        idle_lvl = inv;
        tick();
        check_idle({name, ".post"});
    endtask

    task automatic set_all(input logic [3:0] m, input int d);
        for (int i = 0; i < NCH; i++) begin
            t_mode[i] = m;
            t_dly[i]  = d;
        end
    endtask

    initial begin
        rst = 1'b1;
        fs = 1'b0;
        trgg_cmd = '0;
        set_abort(1'b0);
        repeat (3) tick();
        check_val("reset.pin",  32'(pin_out), 32'd0);
        check_val("reset.done", 32'(ch_done), 32'd0);
        check_val("reset.fd",   32'(fd),      32'd0);
        rst = 1'b0;
        tick();

        set_all(4'h1, 5);
        run_cmd("pulse_d5", -1, 2, -1, -1);

        t_mode[0] = 4'h0; t_dly[0] = 7;
        t_mode[1] = 4'h1; t_dly[1] = 0;
        t_mode[2] = 4'h2; t_dly[2] = 3;
        t_mode[3] = 4'h2; t_dly[3] = 0;
        run_cmd("mixed", -1, 1, -1, -1);

        set_all(4'h0, 0);
        t_mode[1] = 4'h9; t_dly[1] = 2;
        run_cmd("inv", -1, 0, -1, -1);

        set_all(4'h1, 2);
        run_cmd("rst_mid", -1, 0, 4, -1);
        run_cmd("after_rst", -1, 0, -1, -1);

        set_all(4'h2, 6);
        t_mode[0] = 4'h1;
        run_cmd("fs_drop", 1, 0, -1, -1);

        t_mode[0] = 4'h1; t_dly[0] = MAX_D;
        t_mode[1] = 4'hA; t_dly[1] = MAX_D;
        t_mode[2] = 4'hF; t_dly[2] = 9;
        t_mode[3] = 4'h2; t_dly[3] = 1;
        run_cmd("max_delay", -1, 1, -1, -1);

`ifdef TRGG_ABORT_EN
        set_all(4'h2, 100);
        run_cmd("abort", -1, 1, -1, 10);
`endif

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NCH; i++) begin
                t_mode[i] = 4'($urandom_range(0, 15));
                t_dly[i]  = int'($urandom_range(0, 20));
            end
            run_cmd($sformatf("rnd%0d", r),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1,
                    int'($urandom_range(0, 3)), -1,
`ifdef TRGG_ABORT_EN
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 25)) : -1
`else
                    -1
`endif
                    );
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_trgg_gen

`default_nettype wire
